// File: rtl/led_bar_ctrl_if.sv
// Bundle between the level source / LED driver and the LED bar controller.
// Latency: none (wires only).
// Backpressure: none; level_valid is a one-cycle qualifier and write a one-cycle strobe.
//
// Signals:
//   level       [7:0]  acoustic magnitude sample, unsigned
//   level_valid        one-cycle qualifier for level
//   busy               controller is latching or sweeping the bar
//   rgb_data    [23:0] colour word to the LED driver write port
//   led_num     [7:0]  LED index to the LED driver write port
//   write              one-cycle write strobe to the LED driver
// Modports: slave = controller side, master = source/driver side.
interface led_bar_ctrl_if;
  logic [7:0]  level;
  logic        level_valid;
  logic        busy;
  logic [23:0] rgb_data;
  logic [7:0]  led_num;
  logic        write;

  modport slave (
    input  level,
    input  level_valid,
    output busy,
    output rgb_data,
    output led_num,
    output write
  );

  modport master (
    output level,
    output level_valid,
    input  busy,
    input  rgb_data,
    input  led_num,
    input  write
  );
endinterface

// File: rtl/led_bar_ctrl.sv
// Turns an audio level sample into a bar graph by writing every LED of the chain in turn.
// Latency: level_valid in cycle N gives the led 0 write in N+2 and the last write in N+1+NUM_LEDS.
// Backpressure: none; a level arriving mid-sweep is kept as a single newest-wins pending value.
//
// Ports:
//   clk, reset   single clock, synchronous active-high reset
//   bus          led_bar_ctrl_if.slave (level/level_valid in, busy/rgb_data/led_num/write out)
//   host_rgb, host_led, host_write, host_ready
//                optional direct host write port, present only when LED_BAR_HOST_PORT_EN
//                is defined; the default build has no host port.
module led_bar_ctrl #(
  parameter int          NUM_LEDS  = 8,
  parameter logic [23:0] ON_COLOR  = 24'h00FF00,
  parameter logic [23:0] OFF_COLOR = 24'h000000
) (
  input  logic              clk,
  input  logic              reset,
  led_bar_ctrl_if.slave     bus
`ifdef LED_BAR_HOST_PORT_EN
  ,
  input  logic [23:0]       host_rgb,
  input  logic [7:0]        host_led,
  input  logic              host_write,
  output logic              host_ready
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_SWEEP = 2'd2;

  localparam logic [7:0]  LAST_IDX = 8'(NUM_LEDS - 1);
  localparam logic [15:0] MULT     = 16'(NUM_LEDS + 1);

  logic [1:0]  state;
  logic [7:0]  lvl_r;
  logic [7:0]  pend_r;
  logic        pending_valid;
  logic [7:0]  lit;
  logic [7:0]  idx;

  // 8-bit level times at most 256 fits in 16 bits, so the product is never truncated.
  logic [15:0] prod;
  logic [7:0]  lit_calc;
  logic [7:0]  idx_nxt;
  logic        host_acc;

  assign prod     = {8'd0, lvl_r} * MULT;
  assign lit_calc = prod[15:8];
  assign idx_nxt  = idx + 8'd1;

`ifdef LED_BAR_HOST_PORT_EN
  localparam logic [8:0] NUM_LEDS9 = 9'(NUM_LEDS);
  // Accept is combinational so the host sees it in the same cycle it asks.
  assign host_ready = (state == S_IDLE) && !reset && host_write;
  assign host_acc   = host_ready;
`else
  assign host_acc   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      lvl_r         <= 8'd0;
      pend_r        <= 8'd0;
      pending_valid <= 1'b0;
      lit           <= 8'd0;
      idx           <= 8'd0;
      bus.busy      <= 1'b0;
      bus.write     <= 1'b0;
      bus.rgb_data  <= 24'd0;
      bus.led_num   <= 8'd0;
    end else begin
      bus.write <= 1'b0;
      case (state)
        S_IDLE: begin
          if (host_acc) begin
            // Host is served first; a coincident level waits one cycle as pending.
`ifdef LED_BAR_HOST_PORT_EN
            if ({1'b0, host_led} < NUM_LEDS9) begin
              bus.write    <= 1'b1;
              bus.led_num  <= host_led;
              bus.rgb_data <= host_rgb;
            end
`endif
            if (bus.level_valid) begin
              pend_r        <= bus.level;
              pending_valid <= 1'b1;
            end
          end else if (bus.level_valid) begin
            // A fresh sample supersedes anything pending.
            lvl_r         <= bus.level;
            pending_valid <= 1'b0;
            bus.busy      <= 1'b1;
            state         <= S_LATCH;
          end else if (pending_valid) begin
            lvl_r         <= pend_r;
            pending_valid <= 1'b0;
            bus.busy      <= 1'b1;
            state         <= S_LATCH;
          end
        end

        S_LATCH: begin
          // Outputs are registered, so the led 0 write is loaded here from the
          // freshly computed bar length to land two cycles after the sample.
          lit          <= lit_calc;
          idx          <= 8'd0;
          bus.write    <= 1'b1;
          bus.led_num  <= 8'd0;
          bus.rgb_data <= (lit_calc != 8'd0) ? ON_COLOR : OFF_COLOR;
          state        <= S_SWEEP;
          if (bus.level_valid) begin
            pend_r        <= bus.level;
            pending_valid <= 1'b1;
          end
        end

        S_SWEEP: begin
          // idx is the LED whose write is on the outputs this cycle.
          if (idx == LAST_IDX) begin
            // Chain the next sweep straight in when a newer level is waiting.
            if (bus.level_valid) begin
              lvl_r         <= bus.level;
              pending_valid <= 1'b0;
              state         <= S_LATCH;
            end else if (pending_valid) begin
              lvl_r         <= pend_r;
              pending_valid <= 1'b0;
              state         <= S_LATCH;
            end else begin
              bus.busy <= 1'b0;
              state    <= S_IDLE;
            end
          end else begin
            idx          <= idx_nxt;
            bus.write    <= 1'b1;
            bus.led_num  <= idx_nxt;
            bus.rgb_data <= (idx_nxt < lit) ? ON_COLOR : OFF_COLOR;
            if (bus.level_valid) begin
              pend_r        <= bus.level;
              pending_valid <= 1'b1;
            end
          end
        end

        default: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
